// File: rtl/e203_exu_wbck_arb.sv
// rtl/e203_exu_wbck_arb.sv - ALU / long-pipe writeback arbiter with a registered regfile write port
// Define E203_WBCK_ARB_RR_EN for round-robin on contested cycles; otherwise the long-pipe always wins.
module e203_exu_wbck_arb #(
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alu_wbck_i_valid,
   output logic               alu_wbck_i_ready,
   input  logic [RFIDX_W-1:0] alu_wbck_i_idx,
   input  logic [XLEN-1:0]    alu_wbck_i_dat,
   input  logic               longp_wbck_i_valid,
   output logic               longp_wbck_i_ready,
   input  logic [RFIDX_W-1:0] longp_wbck_i_idx,
   input  logic [XLEN-1:0]    longp_wbck_i_dat,
   output logic               rf_wbck_wen,
   output logic [RFIDX_W-1:0] rf_wbck_idx,
   output logic [XLEN-1:0]    rf_wbck_dat,
   output logic               rf_wbck_src
);

   logic               both_vld;
   logic               longp_win;
   logic               alu_fire;
   logic               longp_fire;
   logic               any_fire;
   logic [RFIDX_W-1:0] sel_idx;
   logic [XLEN-1:0]    sel_dat;
   logic               do_write;

   assign both_vld = alu_wbck_i_valid & longp_wbck_i_valid;

`ifdef E203_WBCK_ARB_RR_EN
   // 1 = long-pipe has priority; the winner of a contested cycle hands priority to the loser
   logic rr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= 1'b1;
      end else if (both_vld) begin
         rr_ptr <= ~rr_ptr;
      end
   end

   assign longp_win = rr_ptr;
`else
   assign longp_win = 1'b1;
`endif

   assign longp_wbck_i_ready = ~rst & longp_wbck_i_valid & (~alu_wbck_i_valid | longp_win);
   assign alu_wbck_i_ready   = ~rst & alu_wbck_i_valid & (~longp_wbck_i_valid | ~longp_win);

   assign alu_fire   = alu_wbck_i_valid & alu_wbck_i_ready;
   assign longp_fire = longp_wbck_i_valid & longp_wbck_i_ready;
   assign any_fire   = alu_fire | longp_fire;

   assign sel_idx  = longp_fire ? longp_wbck_i_idx : alu_wbck_i_idx;
   assign sel_dat  = longp_fire ? longp_wbck_i_dat : alu_wbck_i_dat;
   // x0 writes still complete the handshake but never reach the regfile
   assign do_write = any_fire & (|sel_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wbck_wen <= 1'b0;
         rf_wbck_idx <= '0;
         rf_wbck_dat <= '0;
         rf_wbck_src <= 1'b0;
      end else begin
         rf_wbck_wen <= do_write;
         if (do_write) begin
            rf_wbck_idx <= sel_idx;
            rf_wbck_dat <= sel_dat;
            rf_wbck_src <= longp_fire;
         end
      end
   end

endmodule
